// File: rtl/pal_field_padder_if.sv
// rtl/pal_field_padder_if.sv - VDG sync inputs and padded sync/hold outputs of pal_field_padder
interface pal_field_padder_if;
  logic HSn;
  logic FSn;
  logic HOLDn;
  logic HSOUTn;
  logic FSOUTn;
  logic PADACT;
  logic PADERR;

  modport master (
    output HSn,
    output FSn,
    input  HOLDn,
    input  HSOUTn,
    input  FSOUTn,
    input  PADACT,
    input  PADERR
  );

  modport slave (
    input  HSn,
    input  FSn,
    output HOLDn,
    output HSOUTn,
    output FSOUTn,
    output PADACT,
    output PADERR
  );
endinterface

// File: rtl/pal_field_padder.sv
// rtl/pal_field_padder.sv - Stretches the VDG's 262-line field to 312 lines by holding the VDG
// through two padding windows per field and generating substitute horizontal syncs meanwhile.
module pal_field_padder #(
  parameter int LINE_CLKS  = 228,
  parameter int HS_CLKS    = 17,
  parameter int PAD1_START = 24,
  parameter int PAD2_START = 1,
  parameter int PAD_LINES  = 25
) (
  input  logic              CLK,
  input  logic              RST,
  pal_field_padder_if.slave sig
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT1      = 3'd1,
    PAD1       = 3'd2,
    WAIT1_DONE = 3'd3,
    WAIT2      = 3'd4,
    PAD2       = 3'd5
  } state_t;

  localparam logic [8:0] LINE_LAST = 9'(LINE_CLKS - 1);
  localparam logic [8:0] HS_WIDTH  = 9'(HS_CLKS);
  localparam logic [7:0] START1    = 8'(PAD1_START);
  localparam logic [7:0] START2    = 8'(PAD2_START);
  localparam logic [7:0] PAD_COUNT = 8'(PAD_LINES);

  state_t     state_q, state_d;
  logic       hs_m_q, hs_m_d;
  logic       hs_s_q, hs_s_d;
  logic       hs_dly_q, hs_dly_d;
  logic       fs_m_q, fs_m_d;
  logic       fs_s_q, fs_s_d;
  logic       fs_dly_q, fs_dly_d;
  logic [7:0] line_cnt_q, line_cnt_d;
  logic [8:0] timer_q, timer_d;
  logic [7:0] pad_cnt_q, pad_cnt_d;
  logic       hold_q, hold_d;
  logic       padact_q, padact_d;
  logic       hsout_q, hsout_d;
  logic       fsout_q, fsout_d;
  logic       paderr_q, paderr_d;

  logic       hs_fall;
  logic       fs_fall;
  logic       fs_rise;
  logic       fs_edge;
  logic       hs_count;
  logic [7:0] line_inc;
  logic       timer_wrap;
  logic       win_done;
  logic       in_pad;

  // Synchronisers, edge detection and the VDG line counter.
  always_comb begin
    hs_m_d   = sig.HSn;
    hs_s_d   = hs_m_q;
    hs_dly_d = hs_s_q;
    fs_m_d   = sig.FSn;
    fs_s_d   = fs_m_q;
    fs_dly_d = fs_s_q;

    hs_fall  = hs_dly_q & ~hs_s_q;
    fs_fall  = fs_dly_q & ~fs_s_q;
    fs_rise  = ~fs_dly_q & fs_s_q;
    fs_edge  = fs_fall | fs_rise;
    // A field edge swallows a coincident line edge.
    hs_count = hs_fall & ~fs_edge;

    line_inc = (line_cnt_q == 8'hFF) ? line_cnt_q : line_cnt_q + 8'd1;

    line_cnt_d = line_cnt_q;
    if (fs_edge) begin
      line_cnt_d = 8'd0;
    end else if (hs_count) begin
      line_cnt_d = line_inc;
    end
  end

  // Window sequencing and the padding line timer.
  always_comb begin
    state_d    = state_q;
    timer_d    = 9'd0;
    pad_cnt_d  = 8'd0;
    paderr_d   = paderr_q;
    timer_wrap = (timer_q == LINE_LAST);
    win_done   = timer_wrap && ((pad_cnt_q + 8'd1) == PAD_COUNT);

    case (state_q)
      IDLE: begin
        if (fs_fall) begin
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (fs_rise) begin
          state_d = WAIT2;
        end else if (hs_count && (line_inc == START1)) begin
          state_d = PAD1;
        end
      end
      WAIT1_DONE: begin
        if (fs_rise) begin
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (fs_fall) begin
          state_d = WAIT1;
        end else if (hs_count && (line_inc == START2)) begin
          state_d = PAD2;
        end
      end
      PAD1, PAD2: begin
        // The VDG is frozen here, so any field edge means the hold failed.
        if (fs_edge) begin
          paderr_d = 1'b1;
          state_d  = fs_fall ? WAIT1 : WAIT2;
        end else if (win_done) begin
          state_d = (state_q == PAD1) ? WAIT1_DONE : IDLE;
        end else begin
          timer_d   = timer_wrap ? 9'd0 : timer_q + 9'd1;
          pad_cnt_d = timer_wrap ? pad_cnt_q + 8'd1 : pad_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_pad   = (state_d == PAD1) || (state_d == PAD2);
    hold_d   = ~in_pad;
    padact_d = in_pad;
    hsout_d  = in_pad ? (timer_d >= HS_WIDTH) : hs_s_q;
    fsout_d  = fs_s_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      hs_m_q     <= 1'b1;
      hs_s_q     <= 1'b1;
      hs_dly_q   <= 1'b1;
      fs_m_q     <= 1'b1;
      fs_s_q     <= 1'b1;
      fs_dly_q   <= 1'b1;
      line_cnt_q <= 8'd0;
      timer_q    <= 9'd0;
      pad_cnt_q  <= 8'd0;
      hold_q     <= 1'b1;
      padact_q   <= 1'b0;
      hsout_q    <= 1'b1;
      fsout_q    <= 1'b1;
      paderr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_m_q     <= hs_m_d;
      hs_s_q     <= hs_s_d;
      hs_dly_q   <= hs_dly_d;
      fs_m_q     <= fs_m_d;
      fs_s_q     <= fs_s_d;
      fs_dly_q   <= fs_dly_d;
      line_cnt_q <= line_cnt_d;
      timer_q    <= timer_d;
      pad_cnt_q  <= pad_cnt_d;
      hold_q     <= hold_d;
      padact_q   <= padact_d;
      hsout_q    <= hsout_d;
      fsout_q    <= fsout_d;
      paderr_q   <= paderr_d;
    end
  end

  assign sig.HOLDn  = hold_q;
  assign sig.HSOUTn = hsout_q;
  assign sig.FSOUTn = fsout_q;
  assign sig.PADACT = padact_q;
  assign sig.PADERR = paderr_q;

endmodule

// File: tb/tb_pal_field_padder.sv
// tb/tb_pal_field_padder.sv - randomized scoreboard bench for pal_field_padder with a clock-gated VDG model
module tb_pal_field_padder;
  localparam int LINE_CLKS   = 48;
  localparam int HS_CLKS     = 7;
  localparam int PAD1_START  = 24;
  localparam int PAD2_START  = 1;
  localparam int PAD_LINES   = 25;
  localparam int WIN_CLKS    = LINE_CLKS * PAD_LINES;
  localparam int FIELD_LINES = 262;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0;
  int fails = 0;
  int win_q[$];
  int field_q[$];

  pal_field_padder_if sig ();

  pal_field_padder #(
    .LINE_CLKS (LINE_CLKS),
    .HS_CLKS   (HS_CLKS),
    .PAD1_START(PAD1_START),
    .PAD2_START(PAD2_START),
    .PAD_LINES (PAD_LINES)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .sig(sig)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_holdn"},  int'(sig.HOLDn),  1);
    check({tag, "_hsoutn"}, int'(sig.HSOUTn), 1);
    check({tag, "_fsoutn"}, int'(sig.FSOUTn), 1);
    check({tag, "_padact"}, int'(sig.PADACT), 0);
    check({tag, "_paderr"}, int'(sig.PADERR), 0);
  endtask

  // Windows a VDG run should trigger: window 1 needs PAD1_START line starts while FSn is low,
  // window 2 needs PAD2_START line starts after FSn rises. FSn edges sit mid-line.
  function automatic logic [1:0] windows_in(input int n_lines, input int fs_start, input int fs_len);
    int low_falls;
    int high_falls;
    low_falls = n_lines - 1 - fs_start;
    if (fs_len < low_falls) low_falls = fs_len;
    high_falls = n_lines - 1 - (fs_start + fs_len);
    return {high_falls >= PAD2_START, low_falls >= PAD1_START};
  endfunction

  // One VDG clock: drive the pins, then the VDG only advances on a CLK where HOLDn is high.
  task automatic vdg_tick(input logic hs, input logic fs);
    int waited;
    waited = 0;
    sig.HSn = hs;
    sig.FSn = fs;
    @(posedge CLK); #1;
    while (!sig.HOLDn && waited <= WIN_CLKS + 16) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (waited > WIN_CLKS + 16) check_range("vdg_hold_bound", waited, 0, WIN_CLKS + 16);
  endtask

  task automatic vdg_field(input int n_lines, input int line_len, input int hs_w,
                           input int fs_start, input int fs_len, output int n_win);
    logic [1:0] w;
    logic fs_low;
    w = windows_in(n_lines, fs_start, fs_len);
    n_win = int'(w[0]) + int'(w[1]);
    if (w[0]) win_q.push_back(WIN_CLKS);
    if (w[1]) win_q.push_back(WIN_CLKS);
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < line_len; c++) begin
        fs_low = (l > fs_start || (l == fs_start && c >= line_len / 2)) &&
                 (l < fs_start + fs_len || (l == fs_start + fs_len && c < line_len / 2));
        vdg_tick(c >= hs_w, ~fs_low);
      end
    end
  endtask

  task automatic do_reset();
    sig.HSn = 1'b1;
    sig.FSn = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: measures every HOLDn-low episode and the HSOUTn pulses between FSOUTn falls.
  initial begin : monitor
    bit in_hold;
    bit prev_hs;
    bit prev_fs;
    bit cnt_active;
    int hold_len;
    int pulses;
    int low_run;
    int shape_bad;
    int last_start;
    int pa_bad;
    int hs_falls;
    int exp_len;
    in_hold = 0; prev_hs = 1; prev_fs = 1; cnt_active = 0;
    hold_len = 0; pulses = 0; low_run = 0; shape_bad = 0; last_start = -1;
    pa_bad = 0; hs_falls = 0;
    forever begin
      @(posedge CLK); #2;
      if (sig.PADACT !== ~sig.HOLDn) pa_bad++;
      if (sig.HOLDn === 1'b0) begin
        if (!in_hold) begin
          in_hold = 1; hold_len = 0; pulses = 0; low_run = 0; shape_bad = 0; last_start = -1;
        end
        if (!sig.HSOUTn && (hold_len == 0 || prev_hs)) begin
          if (last_start >= 0 && hold_len - last_start != LINE_CLKS) shape_bad++;
          last_start = hold_len;
          pulses++;
        end
        if (!sig.HSOUTn) low_run++;
        else if (low_run != 0) begin
          if (low_run != HS_CLKS) shape_bad++;
          low_run = 0;
        end
        hold_len++;
      end else if (in_hold) begin
        in_hold = 0;
        if (win_q.size() == 0) begin
          check("unexpected_window", hold_len, 0);
        end else begin
          exp_len = win_q.pop_front();
          if (exp_len == 0) begin
            check_range("aborted_hold_len", hold_len, 1, WIN_CLKS - 1);
          end else begin
            check("hold_len", hold_len, exp_len);
            check("pad_pulses", pulses, PAD_LINES);
            check("pulse_shape_errors", shape_bad, 0);
          end
          check("padact_vs_holdn", pa_bad, 0);
          pa_bad = 0;
        end
      end
      if (prev_hs && !sig.HSOUTn) hs_falls++;
      if (prev_fs && !sig.FSOUTn) begin
        if (cnt_active) check("hsout_pulses_per_field", hs_falls, field_q.pop_front());
        cnt_active = (field_q.size() > 0);
        hs_falls = 0;
      end
      prev_hs = sig.HSOUTn;
      prev_fs = sig.FSOUTn;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d windows pending", win_q.size());
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int fs0;
    int len_a;
    int len_b;
    int nw0;
    int nw1;
    int nw;
    int n;
    logic [1:0] w;

    sig.HSn = 1'b1;
    sig.FSn = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // Full-field stream: a nominal field, a short field, then into a third field.
    fs0   = $urandom_range(180, 200);
    len_a = $urandom_range(28, 36);
    len_b = $urandom_range(3, 15);
    w = windows_in(FIELD_LINES, fs0, len_a);
    field_q.push_back(FIELD_LINES + PAD_LINES * (int'(w[0]) + int'(w[1])));
    w = windows_in(FIELD_LINES, fs0, len_b);
    field_q.push_back(FIELD_LINES + PAD_LINES * (int'(w[0]) + int'(w[1])));
    vdg_field(FIELD_LINES, $urandom_range(40, 52), $urandom_range(4, 10), fs0, len_a, nw0);
    check("nominal_windows", nw0, 2);
    vdg_field(FIELD_LINES, $urandom_range(40, 52), $urandom_range(4, 10), fs0, len_b, nw1);
    check("short_field_windows", nw1, 1);
    vdg_field(fs0 + 2, $urandom_range(40, 52), $urandom_range(4, 10), fs0, len_a, nw);
    repeat (8) @(posedge CLK);
    #1;
    check("paderr_after_fields", int'(sig.PADERR), 0);
    check("holdn_idle", int'(sig.HOLDn), 1);

    // Illegal FSn rise during line 7 of window 1.
    do_reset();
    vdg_field(2 + PAD1_START, 44, 5, 2, 100, nw);
    win_q.push_back(0);
    sig.HSn = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (sig.HOLDn && n < 10);
    check_range("pad1_entry_clks", n, 1, 3);
    repeat (7 * LINE_CLKS + $urandom_range(0, LINE_CLKS - 1)) @(posedge CLK);
    #1;
    sig.FSn = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!sig.HOLDn && n < 10);
    check_range("abort_release_clks", n, 1, 4);
    check("paderr_set", int'(sig.PADERR), 1);
    check("padact_after_abort", int'(sig.PADACT), 0);
    sig.HSn = 1'b1;
    repeat (200) vdg_tick(1'b1, 1'b1);
    check("paderr_sticky", int'(sig.PADERR), 1);
    do_reset();
    #1;
    check("paderr_cleared_by_rst", int'(sig.PADERR), 0);

    // Reset at line 12 of window 2.
    vdg_field(28, 46, 6, 1, 26, nw);
    win_q.push_back(0);
    sig.HSn = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (sig.HOLDn && n < 10);
    check_range("pad2_entry_clks", n, 1, 3);
    repeat (12 * LINE_CLKS + $urandom_range(0, LINE_CLKS - 1)) @(posedge CLK);
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check_reset_vals("async_rst");
    sig.HSn = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    vdg_field(PAD1_START + 3, $urandom_range(40, 52), $urandom_range(4, 10), 0, 100, nw);
    check("post_reset_window1", nw, 1);

    repeat (20) @(posedge CLK);
    #1;
    check("windows_pending", win_q.size(), 0);
    check("fields_pending", field_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pal_field_padder.md
Name: pal_field_padder

Overview:
- Sits directly downstream of the VDG HSn/FSn line counting.
- Turns the VDG's 262-line NTSC field into a 312-line PAL field by inserting two blocks of padding lines per field.
- Each block is PAD_LINES lines. During padding it stops the VDG with HOLDn and generates substitute horizontal syncs from its own line timer.
- Outputs feed the VDG clock gate and the composite sync mixer.

Parameters:
- LINE_CLKS, 228: CLK cycles per padding line (63.7 us at 3.579545 MHz). Range 32..511.
- HS_CLKS, 17: width of a substitute HSOUTn low pulse in CLK cycles. Must be < LINE_CLKS.
- PAD1_START, 24: count of VDG HSn falling edges after FSn falls before window 1 opens.
- PAD2_START, 1: count of VDG HSn falling edges after FSn rises before window 2 opens.
- PAD_LINES, 25: padding lines per window. Range 1..255.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- HSn  in  1  VDG horizontal sync, active low, asynchronous to CLK.
- FSn  in  1  VDG field sync, active low, asynchronous to CLK.
- HOLDn  out  1  0 = stop the VDG clock.
- HSOUTn  out  1  horizontal sync to the mixer, active low.
- FSOUTn  out  1  field sync to the mixer, active low.
- PADACT  out  1  1 while any padding window is active.
- PADERR  out  1  sticky; set on an illegal FSn edge during padding.

Behaviour:
- Reset values: HOLDn=1, HSOUTn=1, FSOUTn=1, PADACT=0, PADERR=0, state=IDLE, all counters 0. The two-flop synchronisers preset to 1.
- Synchronisation: HSn and FSn each pass through two flops (hs_s, fs_s). Edge detection compares the synchroniser output with a third delayed flop. Edges are seen 2-3 CLKs after the pin changes.
- FSOUTn = fs_s, registered (one additional CLK).
- Line counter: 8 bits, cleared on every fs_s edge, incremented on each hs_s falling edge, saturates at 255.
- States:
  - IDLE: wait for fs_s fall -> WAIT1.
  - WAIT1: when line count reaches PAD1_START -> PAD1. On fs_s rise -> WAIT2 (window 1 skipped, no error).
  - PAD1: padding window (rules below). When the window completes -> WAIT1_DONE, which waits for fs_s rise -> WAIT2.
  - WAIT2: when line count reaches PAD2_START -> PAD2. On fs_s fall -> WAIT1.
  - PAD2: padding window. When the window completes -> IDLE.
- Window entry is in the same cycle as the hs_s fall that meets the count.
- Padding window:
  - HOLDn=0 and PADACT=1 from the entry cycle.
  - 9-bit line timer runs 0..LINE_CLKS-1 and wraps.
  - HSOUTn=0 while timer < HS_CLKS.
  - 8-bit pad counter increments on each timer wrap.
  - The window ends on the wrap at which the pad counter reaches PAD_LINES. That cycle HOLDn=1, PADACT=0, timer and pad counter clear.
  - Exactly PAD_LINES*LINE_CLKS cycles of HOLDn=0.
- Outside a window: HSOUTn = hs_s, registered.
- Simultaneous events: an hs_s fall in the PAD exit cycle is forwarded and counted. An fs_s edge and an hs_s fall in the same cycle: the edge wins, the counter is cleared, and that hs_s fall is not counted.
- Illegal FSn edge during PAD1/PAD2 (VDG should be held):
  - Set PADERR.
  - Release HOLDn next cycle.
  - Abort the window and go to WAIT1 on a fall or WAIT2 on a rise.
  - PADERR clears only on RST.
- RST mid-window: HOLDn returns to 1 immediately (asynchronous); state returns to IDLE.

Test Plan:
- Nominal field with default parameters. Stimulus: FSn low, then 24 HSn pulses at 63.5 us. Required: HOLDn falls within 3 CLKs of the 24th HSn fall and stays low exactly 5700 CLKs; HSOUTn shows 25 low pulses of 17 CLKs, 228 CLKs apart; PADACT tracks HOLDn inverted.
- Window 2. Stimulus: FSn rises, then 1 HSn pulse. Required: a second 5700-CLK hold with 25 substitute pulses, then state IDLE, HOLDn=1.
- Full field. Stimulus: drive a 262-line VDG stream. Required: 312 HSOUTn pulses between consecutive FSOUTn falls; PADERR=0.
- Short field. Stimulus: FSn rises after only 10 HSn. Required: no PAD1 and no error; PAD2 still runs 25 lines.
- Illegal edge. Stimulus: FSn toggles at line 7 of PAD1. Required: PADERR=1; HOLDn=1 within 4 CLKs; PADERR stays 1 until RST.
- Reset mid-window. Stimulus: assert RST at line 12 of PAD2. Required: HOLDn=1 with no CLK edge; all outputs at reset values; after release the next FSn fall starts WAIT1.
